// File: rtl/countdown_sequencer.sv
// countdown_sequencer: drives load/enable/countdown strobes of an up/down counter from
// start/pause/abort requests and pulses expired when the fed-back count reaches zero.
module countdown_sequencer #(
    parameter int COUNT_WIDTH = 8,
    parameter int PRESCALE    = 65_000_000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   pause,
    input  logic                   abort,
    input  logic [COUNT_WIDTH-1:0] init_value,
    input  logic [COUNT_WIDTH-1:0] count_in,
    output logic                   cnt_load,
    output logic [COUNT_WIDTH-1:0] cnt_load_number,
    output logic                   cnt_enable,
    output logic                   cnt_countdown,
    output logic                   running,
    output logic                   expired
);
    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, PAUSED, DONE} state_t;

    state_t                 state_q, state_d;
    logic [PW-1:0]          presc_q, presc_d;
    logic [COUNT_WIDTH-1:0] value_q, value_d;
    logic                   nz_q;

    always_comb begin
        state_d = state_q;
        value_d = value_q;
        if (abort && state_q != IDLE)
            state_d = IDLE;
        else if (start && state_q != LOAD) begin
            state_d = LOAD;
            value_d = init_value;
        end else
            case (state_q)
                LOAD:    state_d = RUN;
                RUN:     state_d = count_in == '0 ? DONE : pause ? PAUSED : RUN;
                PAUSED:  state_d = pause ? RUN : PAUSED;
                default: state_d = IDLE;
            endcase
        // the prescaler only advances on edges that keep the FSM in RUN
        presc_d = state_q == LOAD ? '0 :
                  (state_q == RUN && state_d == RUN) ? (presc_q == LAST ? '0 : presc_q + 1'b1) :
                  presc_q;
    end

    // nz_q lags count_in by a cycle; the count cannot change in the cycle before a tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            presc_q <= '0;
            value_q <= '0;
            nz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            value_q <= value_d;
            nz_q    <= count_in != '0;
        end
    end

    assign cnt_load        = state_q == LOAD;
    assign cnt_load_number = cnt_load ? value_q : '0;
    assign cnt_enable      = state_q == RUN && presc_q == LAST && nz_q;
    assign cnt_countdown   = state_q inside {LOAD, RUN, PAUSED};
    assign running         = state_q inside {RUN, PAUSED};
    assign expired         = state_q == DONE;
endmodule

// File: tb/tb_countdown_sequencer.sv
// tb_countdown_sequencer: directed checks of the sequencer driving a behavioural up/down counter.
module tb_countdown_sequencer;
    localparam int W = 8;

    logic         clk = 1'b0, rst = 1'b0, start = 1'b0, pause = 1'b0, abort = 1'b0;
    logic [W-1:0] init_value = '0, count_in, cnt_load_number;
    logic         cnt_load, cnt_enable, cnt_countdown, running, expired;
    int           checks = 0, errors = 0;

    always #5 clk = ~clk;

    countdown_sequencer #(.COUNT_WIDTH(W), .PRESCALE(4)) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort),
        .init_value(init_value), .count_in(count_in),
        .cnt_load(cnt_load), .cnt_load_number(cnt_load_number), .cnt_enable(cnt_enable),
        .cnt_countdown(cnt_countdown), .running(running), .expired(expired)
    );

    // loadable up/down counter fed back into count_in
    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_in <= '0;
        else if (cnt_load) count_in <= cnt_load_number;
        else if (cnt_enable) count_in <= cnt_countdown ? count_in - 1'b1 : count_in + 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // cd == 2 leaves cnt_countdown unchecked
    task automatic outs(input string tag, input logic ld, input logic [W-1:0] num, input logic en,
                        input int cd, input logic run, input logic ex);
        chk({tag, " load"}, cnt_load, ld);
        chk({tag, " num"}, cnt_load_number, num);
        chk({tag, " enable"}, cnt_enable, en);
        if (cd != 2) chk({tag, " countdown"}, cnt_countdown, cd);
        chk({tag, " running"}, running, run);
        chk({tag, " expired"}, expired, ex);
    endtask

    // start sampled in the current cycle (cycle 0); returns at cycle 1
    task automatic begin_run(input logic [W-1:0] v);
        init_value = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #2 rst = 1'b1;
        #2 outs("reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        outs("idle", 0, 0, 0, 0, 0, 0);

        begin_run(3);
        for (int c = 1; c <= 16; c++) begin
            if (c > 1) @(negedge clk);
            outs($sformatf("t1 c%0d", c), c == 1, c == 1 ? 8'd3 : 8'd0, c == 5 || c == 9 || c == 13,
                 c == 15 ? 2 : int'(c <= 14), c >= 2 && c <= 14, c == 15);
            if (c >= 2) chk($sformatf("t1 count c%0d", c), count_in, c <= 5 ? 3 : c <= 9 ? 2 : c <= 13 ? 1 : 0);
        end

        begin_run(0);
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) @(negedge clk);
            outs($sformatf("t2 c%0d", c), c == 1, 0, 0, c == 3 ? 2 : int'(c <= 2), c == 2, c == 3);
            if (c >= 2) chk($sformatf("t2 count c%0d", c), count_in, 0);
        end

        begin_run(5);
        for (int c = 1; c <= 25; c++) begin
            if (c > 1) @(negedge clk);
            outs($sformatf("t3 c%0d", c), c == 1, c == 1 ? 8'd5 : 8'd0, c == 23, int'(c <= 24), c >= 2 && c <= 24, 0);
            if (c >= 2) chk($sformatf("t3 count c%0d", c), count_in, c <= 23 ? 5 : 4);
            pause = c == 3 || c == 20;
            abort = c == 24;
        end
        pause = 1'b0;
        abort = 1'b0;

        begin_run(3);
        init_value = 9;
        for (int c = 1; c <= 17; c++) begin
            if (c > 1) @(negedge clk);
            outs($sformatf("t4 c%0d", c), c == 1 || c == 8, c == 1 ? 8'd3 : c == 8 ? 8'd9 : 8'd0,
                 c == 5 || c == 12 || c == 16, int'(c <= 16), c >= 2 && c != 8 && c != 17, 0);
            if (c >= 2 && c <= 16)
                chk($sformatf("t4 count c%0d", c), count_in, c <= 5 ? 3 : c <= 8 ? 2 : c <= 12 ? 9 : 8);
            start = c == 7;
            abort = c == 16;
        end
        start = 1'b0;
        abort = 1'b0;

        begin_run(7);
        for (int c = 1; c <= 7; c++) begin
            if (c > 1) @(negedge clk);
            outs($sformatf("t5 c%0d", c), c == 1, c == 1 ? 8'd7 : 8'd0, 0, int'(c <= 5), c >= 2 && c <= 5, 0);
            if (c >= 2) chk($sformatf("t5 count c%0d", c), count_in, 7);
            init_value = 2;
            pause = c == 3 || c == 5;
            abort = c == 5;
            start = c == 5;
        end
        pause = 1'b0;
        abort = 1'b0;
        start = 1'b0;

        begin_run(4);
        for (int c = 2; c <= 5; c++) @(negedge clk);
        chk("t6 enable before rst", cnt_enable, 1);
        #1 rst = 1'b1;
        #1 outs("t6 async rst", 0, 0, 0, 0, 0, 0);
        chk("t6 count rst", count_in, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            outs($sformatf("t6 post c%0d", c), 0, 0, 0, 0, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
